// File: rtl/wir_pkg.sv
// rtl/wir_pkg.sv - shared WIR width, opcodes, capture value and strobe bundle
package wir_pkg;

  localparam int WIR_W = 3;

  localparam logic [WIR_W-1:0] OP_BYPASS   = 3'b000;
  localparam logic [WIR_W-1:0] OP_WPC      = 3'b001;
  localparam logic [WIR_W-1:0] OP_EXTEST   = 3'b010;
  localparam logic [WIR_W-1:0] OP_INTEST   = 3'b011;
  localparam logic [WIR_W-1:0] CAPTURE_VAL = 3'b001;

  typedef struct packed {
    logic bypass;
    logic wpc;
    logic extest;
    logic intest;
  } wir_strobes_t;

  localparam wir_strobes_t STROBES_BYPASS = '{bypass: 1'b1, default: 1'b0};

endpackage

// File: rtl/wir_decode.sv
// rtl/wir_decode.sv - combinational opcode to one-hot strobe and illegal flag
module wir_decode
  import wir_pkg::*;
(
  input  logic [WIR_W-1:0] opcode,
  output wir_strobes_t     strobes,
  output logic             illegal
);

  always_comb begin
    strobes = '0;
    illegal = 1'b0;
    case (opcode)
      OP_BYPASS: strobes.bypass = 1'b1;
      OP_WPC:    strobes.wpc    = 1'b1;
      OP_EXTEST: strobes.extest = 1'b1;
      OP_INTEST: strobes.intest = 1'b1;
      // Unassigned codes fall back to BYPASS so the wrapper stays transparent
      default: begin
        strobes.bypass = 1'b1;
        illegal        = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/wir_ctrl.sv
// rtl/wir_ctrl.sv - P1500 wrapper instruction register with registered decode
module wir_ctrl
  import wir_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic SelectWIR,
  input  logic CaptureWR,
  input  logic ShiftWR,
  input  logic UpdateWR,
  input  logic WSI,
  output logic WSO_wir,
  output logic wir_bypass,
  output logic wir_wpc,
  output logic wir_extest,
  output logic wir_intest,
  output logic wir_illegal
);

  logic [WIR_W-1:0] shift_reg;
  logic [WIR_W-1:0] update_reg;
  wir_strobes_t     dec_strobes;
  logic             dec_illegal;
  wir_strobes_t     strobes_q;
  logic             illegal_q;

  // Update samples the pre-edge shift stage, so update and shift may coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg  <= '0;
      update_reg <= OP_BYPASS;
    end else if (SelectWIR) begin
      if (CaptureWR)
        shift_reg <= CAPTURE_VAL;
      else if (ShiftWR)
        shift_reg <= {WSI, shift_reg[WIR_W-1:1]};
      if (UpdateWR)
        update_reg <= shift_reg;
    end
  end

  wir_decode u_decode (
    .opcode  (update_reg),
    .strobes (dec_strobes),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      strobes_q <= STROBES_BYPASS;
      illegal_q <= 1'b0;
    end else begin
      strobes_q <= dec_strobes;
      illegal_q <= dec_illegal;
    end
  end

  assign WSO_wir     = shift_reg[0];
  assign wir_bypass  = strobes_q.bypass;
  assign wir_wpc     = strobes_q.wpc;
  assign wir_extest  = strobes_q.extest;
  assign wir_intest  = strobes_q.intest;
  assign wir_illegal = illegal_q;

endmodule

// File: tb/tb_wir_ctrl.sv
// tb/tb_wir_ctrl.sv - scoreboard bench for wir_ctrl against a queue-based model
module tb_wir_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic SelectWIR = 1'b0;
  logic CaptureWR = 1'b0;
  logic ShiftWR = 1'b0;
  logic UpdateWR = 1'b0;
  logic WSI = 1'b0;
  logic WSO_wir;
  logic wir_bypass;
  logic wir_wpc;
  logic wir_extest;
  logic wir_intest;
  logic wir_illegal;

  int errors = 0;
  int checks = 0;

  wir_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .SelectWIR   (SelectWIR),
    .CaptureWR   (CaptureWR),
    .ShiftWR     (ShiftWR),
    .UpdateWR    (UpdateWR),
    .WSI         (WSI),
    .WSO_wir     (WSO_wir),
    .wir_bypass  (wir_bypass),
    .wir_wpc     (wir_wpc),
    .wir_extest  (wir_extest),
    .wir_intest  (wir_intest),
    .wir_illegal (wir_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sr;
    logic       wso;
    logic [3:0] oh;   // {bypass, wpc, extest, intest}
    logic       ill;
  } exp_t;

  exp_t exp_q[$];

  // Model: shift stage as a bit queue (index 0 = bit that leaves first)
  bit sq[$] = '{0, 0, 0};
  int held = 0;
  int out_code = 0;

  function automatic int q_value();
    int v = 0;
    for (int i = 0; i < 3; i++) v += int'(sq[i]) << i;
    return v;
  endfunction

  function automatic logic [3:0] onehot_of(int code);
    case (code)
      1: return 4'b0100;
      2: return 4'b0010;
      3: return 4'b0001;
      default: return 4'b1000;
    endcase
  endfunction

  task automatic step(input bit r, input bit s, input bit c, input bit sh,
                      input bit u, input bit w);
    exp_t e;
    int pre;
    rst = r; SelectWIR = s; CaptureWR = c; ShiftWR = sh; UpdateWR = u; WSI = w;
    @(posedge clk);
    if (r) begin
      sq = '{0, 0, 0};
      held = 0;
      out_code = 0;
    end else begin
      out_code = held;
      if (s) begin
        pre = q_value();
        if (u) held = pre;
        if (c) sq = '{1, 0, 0};
        else if (sh) begin
          void'(sq.pop_front());
          sq.push_back(w);
        end
      end
    end
    e.sr  = 3'(q_value());
    e.wso = sq[0];
    e.oh  = onehot_of(out_code);
    e.ill = (out_code >= 4);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0);
  endtask

  task automatic shift_in(input int code);
    step(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, bit'((code >> i) & 1));
  endtask

  task automatic load(input int code);
    shift_in(code);
    step(0, 1, 0, 0, 1, 0);
    idle(2);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({wir_bypass, wir_wpc, wir_extest, wir_intest} !== e.oh) begin
        errors++;
        $display("FAIL strobes: got %b want %b at %0t",
                 {wir_bypass, wir_wpc, wir_extest, wir_intest}, e.oh, $time);
      end
      checks++;
      if (wir_illegal !== e.ill) begin
        errors++;
        $display("FAIL illegal: got %b want %b at %0t", wir_illegal, e.ill, $time);
      end
      checks++;
      if (WSO_wir !== e.wso) begin
        errors++;
        $display("FAIL wso: got %b want %b at %0t", WSO_wir, e.wso, $time);
      end
      checks++;
      if (dut.shift_reg !== e.sr) begin
        errors++;
        $display("FAIL shift_reg: got %b want %b at %0t", dut.shift_reg, e.sr, $time);
      end
      checks++;
      if ($countones({wir_bypass, wir_wpc, wir_extest, wir_intest}) != 1) begin
        errors++;
        $display("FAIL onehot: got %b want exactly one set at %0t",
                 {wir_bypass, wir_wpc, wir_extest, wir_intest}, $time);
      end
    end
  end

  initial begin
    @(negedge clk);
    // Reset with random strobes
    for (int i = 0; i < 2; i++)
      step(1, bit'($urandom), bit'($urandom), bit'($urandom), bit'($urandom), bit'($urandom));
    // Load EXTEST: capture, shift 0,1,0, update
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    step(0, 1, 0, 1, 0, 1);
    step(0, 1, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0);
    idle(2);
    // INTEST held, shift WPC without update, then update
    load(3);
    shift_in(1);
    idle(2);
    step(0, 1, 0, 0, 1, 0);
    idle(2);
    // Illegal opcode then recovery
    load(6);
    idle(1);
    load(3);
    // Simultaneous update+shift, then capture+shift
    shift_in(2);
    step(0, 1, 0, 1, 1, 1);
    idle(2);
    step(0, 1, 1, 1, 0, 1);
    idle(1);
    // Deselected strobes toggle
    for (int i = 0; i < 6; i++)
      step(0, 0, bit'($urandom), bit'($urandom), bit'($urandom), bit'($urandom));
    // Mid-shift reset after two of three shifts
    load(1);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 1);
    step(0, 1, 0, 1, 0, 1);
    step(1, 1, 0, 1, 0, 1);
    idle(2);
    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 5) == 0), bit'($urandom),
           ($urandom_range(0, 3) == 0), bit'($urandom));
    idle(1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wir_ctrl.md
Name: wir_ctrl

Overview:
- IEEE P1500 Wrapper Instruction Register (WIR) for the s349 core wrapper.
- Shifts the instruction in serially from WSI under WSP control and holds it in an update stage.
- Decodes the held instruction into the one-hot strobes wir_bypass, wir_wpc, wir_extest and wir_intest.
- These strobes drive the wrapper mux/scan-enable select generator. This block is the producer end of that instruction interface.

Parameters:
- WIR_W, 3, instruction width (shift and update stages).
- CAPTURE_VAL, 3'b001, value loaded into the shift stage on CaptureWR.

Ports:
- clk  in  1  wrapper clock (WRCK); all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- SelectWIR  in  1  WIR selected; CaptureWR, ShiftWR and UpdateWR are ignored when 0
- CaptureWR  in  1  capture strobe
- ShiftWR  in  1  shift strobe
- UpdateWR  in  1  update strobe
- WSI  in  1  serial data in
- WSO_wir  out  1  serial data out = shift_reg[0] (combinational from register)
- wir_bypass  out  1  one-hot decode, registered
- wir_wpc  out  1  one-hot decode, registered
- wir_extest  out  1  one-hot decode, registered
- wir_intest  out  1  one-hot decode, registered
- wir_illegal  out  1  held instruction is an unassigned opcode, registered

Behaviour:
- Reset (rst=1 at a clk edge):
  - shift_reg=0 and update_reg=0 (BYPASS).
  - Outputs: wir_bypass=1, the other three strobes 0, wir_illegal=0, WSO_wir=0.
  - rst overrides all strobes in that cycle.
- Opcodes: 3'b000 BYPASS, 3'b001 WPC, 3'b010 EXTEST, 3'b011 INTEST. Opcodes 3'b100 to 3'b111 are illegal.
- Shift stage, when SelectWIR=1; priority CaptureWR > ShiftWR:
  - CaptureWR: shift_reg <= CAPTURE_VAL.
  - ShiftWR: shift_reg <= {WSI, shift_reg[WIR_W-1:1]}. The LSB goes out first on WSO_wir, and WSI enters the MSB.
  - Neither strobe: hold.
- Update stage, when SelectWIR=1 and UpdateWR=1: update_reg <= shift_reg, using the value held before this edge.
  - UpdateWR together with ShiftWR or CaptureWR in the same cycle is legal: update takes the pre-edge shift_reg, and the shift stage still performs its own operation.
- When SelectWIR=0, both stages hold.
- Decode:
  - Outputs are registered, one cycle after update_reg changes. The new instruction appears on the outputs 2 edges after the UpdateWR edge.
  - Exactly one of the four strobes is 1 at all times, including during and after reset.
  - An illegal opcode forces wir_bypass=1 and wir_illegal=1. wir_illegal stays high while the illegal code is held, and clears on the next legal update.
- Opcode changes appear only through UpdateWR. Shifting never glitches the decoded outputs.
- Mid-operation reset: any partial shift is discarded and the decode returns to BYPASS on the next edge.

Decomposition:
- Shared package wir_pkg holds:
  - WIR_W
  - the opcode constants OP_BYPASS, OP_WPC, OP_EXTEST, OP_INTEST
  - CAPTURE_VAL
  - a struct or bundle type for the four one-hot strobes
- Sub-module wir_decode: combinational opcode to {one-hot, illegal} mapping. It is reused by the wrapper boundary-register checker. The output registers stay in wir_ctrl.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with random strobes -> wir_bypass=1, other strobes 0, wir_illegal=0, WSO_wir=0.
2. Load EXTEST:
   - Stimulus: SelectWIR=1, CaptureWR 1 cycle, ShiftWR 3 cycles with WSI=0,1,0 (LSB first), then UpdateWR 1 cycle.
   - Response: WSO_wir shows 1,0,0 during the shift. Two edges after UpdateWR, wir_extest=1 and the others 0.
3. Shift without update: with INTEST held, shift in 001 without UpdateWR -> outputs stay wir_intest=1 throughout. A later UpdateWR switches to wir_wpc=1.
4. Illegal opcode: shift in 3'b110 and update -> wir_bypass=1 and wir_illegal=1. Then load 3'b011 -> wir_intest=1 and wir_illegal=0.
5. Simultaneous strobes:
   - Stimulus: shift_reg=010, then UpdateWR and ShiftWR in the same cycle with WSI=1.
   - Response: update_reg=010 (EXTEST) and shift_reg=101. With CaptureWR and ShiftWR together, shift_reg=001.
6. Deselect and mid-shift reset:
   - SelectWIR=0 with all strobes toggling -> shift_reg, update_reg and outputs are unchanged.
   - rst asserted after 2 of 3 shift cycles -> BYPASS and shift_reg=0 on the next edge.
